// File: rtl/boot_copier.sv
// boot_copier: reset-time boot sequencer. Copies WORDS 32-bit words from SPI flash
// (starting at flash word FLASH_WORD_OFFSET) into on-chip RAM, then releases the CPU.
//
// Optional feature macro: BOOT_COPY_CHECKSUM_EN
//   defined   -> checksum is the running mod-2^32 sum of every word written
//   undefined -> checksum is tied to zero and no adder exists
//
// Ports:
//   clk                 system clock, rising edge
//   reset               synchronous active-high; restarts the copy at word 0
//   flash_rstrb         one-cycle read strobe to spi_flash
//   flash_word_address  flash word address presented with the strobe
//   flash_rdata         word from flash, valid once flash_rbusy drops
//   flash_rbusy         flash transfer in progress
//   ram_addr            RAM byte address of the current word
//   ram_wdata           RAM write data (flash_rdata passthrough)
//   ram_wmask           byte write mask, 4'hF only in the write cycle
//   cpu_reset           processor reset, high until the copy completes
//   done                copy complete, sticky until reset
//   copy_count          number of words written so far
//   checksum            running sum of written words (see macro above)
module boot_copier #(
    parameter int unsigned WORDS             = 1536,
    parameter logic [14:0] FLASH_WORD_OFFSET = 15'h2000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        flash_rstrb,
    output logic [14:0] flash_word_address,
    input  logic [31:0] flash_rdata,
    input  logic        flash_rbusy,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    output logic [3:0]  ram_wmask,
    output logic        cpu_reset,
    output logic        done,
    output logic [11:0] copy_count,
    output logic [31:0] checksum
);

    typedef enum logic [4:0] {
        StIssue = 5'b00001,
        StArm   = 5'b00010,
        StWait  = 5'b00100,
        StWrite = 5'b01000,
        StDone  = 5'b10000
    } state_e;

    localparam logic [10:0] LastIdx = 11'(WORDS - 1);

    state_e      state_q, state_d;
    logic [10:0] idx_q;
    logic [11:0] count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIssue;
            idx_q   <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == StWrite) begin
                count_q <= count_q + 12'd1;
                // idx stays on the last word so the address outputs stay stable after done
                if (idx_q != LastIdx) begin
                    idx_q <= idx_q + 11'd1;
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIssue: state_d = StArm;
            // spi_flash raises busy on the falling edge, so busy is not trusted here yet
            StArm:   state_d = StWait;
            StWait:  if (!flash_rbusy) state_d = StWrite;
            StWrite: state_d = (idx_q == LastIdx) ? StDone : StIssue;
            StDone:  state_d = StDone;
            default: state_d = StIssue;
        endcase
    end

    // Strobe and write are masked while reset is held so the block shows its idle values.
    assign flash_rstrb        = (state_q == StIssue) && !reset;
    assign ram_wmask          = ((state_q == StWrite) && !reset) ? 4'hF : 4'h0;
    assign flash_word_address = FLASH_WORD_OFFSET + {4'b0, idx_q};
    assign ram_addr           = {19'b0, idx_q, 2'b00};
    assign ram_wdata          = flash_rdata;
    assign done               = (state_q == StDone);
    assign cpu_reset          = ~done;
    assign copy_count         = count_q;

`ifdef BOOT_COPY_CHECKSUM_EN
    logic [31:0] sum_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sum_q <= '0;
        end else if (state_q == StWrite) begin
            sum_q <= sum_q + flash_rdata;
        end
    end

    assign checksum = sum_q;
`else
    assign checksum = 32'h0;
`endif

endmodule
